// File: rtl/vls_req_buffer_pkg.sv
// Shared vector-memory definitions: default widths and the store-microop decode
// used by the request buffer.
package vls_req_buffer_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ADDR_BITS      = 32;
  localparam int unsigned DEF_BLOCK_ID_START = 5;
  localparam int unsigned DEF_MICROOP_WIDTH  = 7;
  localparam int unsigned DEF_TICKET_WIDTH   = 5;
  localparam int unsigned DEF_SIZE_WIDTH     = 3;
  localparam int unsigned DEF_DEPTH          = 6;

  // Memory-class field of the microop: bits [4:3], 2'b11 marks a store.
  localparam int unsigned MOP_CLASS_LSB = 3;
  localparam logic [1:0]  MOP_CLASS_STORE = 2'b11;

  function automatic logic is_store_class(input logic [1:0] mop_class);
    return mop_class == MOP_CLASS_STORE;
  endfunction

endpackage

// File: rtl/vls_req_buffer_block_match_cmp.sv
// Cache-block ID comparator: two addresses match when their bits above the
// block offset are equal.
module block_match_cmp #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned BLOCK_ID_START = 5
) (
  input  logic [ADDR_BITS-1:0] a,
  input  logic [ADDR_BITS-1:0] b,
  output logic                 match
);

  assign match = (a[ADDR_BITS-1:BLOCK_ID_START] == b[ADDR_BITS-1:BLOCK_ID_START]);

  // Offset bits inside the block never take part in the comparison.
  logic unused_offset;
  assign unused_offset = ^{a[BLOCK_ID_START-1:0], b[BLOCK_ID_START-1:0]};

endmodule

// File: rtl/vls_req_buffer.sv
// Vector load/store request FIFO with per-entry fill tracking and a
// combinational store-hazard probe.
module vls_req_buffer
  import vls_req_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_BITS      = DEF_ADDR_BITS,
  parameter int unsigned BLOCK_ID_START = DEF_BLOCK_ID_START,
  parameter int unsigned MICROOP_WIDTH  = DEF_MICROOP_WIDTH,
  parameter int unsigned TICKET_WIDTH   = DEF_TICKET_WIDTH,
  parameter int unsigned SIZE_WIDTH     = DEF_SIZE_WIDTH,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  localparam int unsigned PTR_W         = $clog2(DEPTH),
  localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_BITS-1:0]     write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [TICKET_WIDTH-1:0]  write_ticket,
  input  logic [MICROOP_WIDTH-1:0] write_microop,
  input  logic [SIZE_WIDTH-1:0]    write_size,
  input  logic                     valid_update_i,
  input  logic [ADDR_BITS-1:0]     update_address_i,
  input  logic                     flush_i,
  input  logic                     pop,
  output logic                     head_is_store,
  output logic                     head_is_fetched,
  output logic [ADDR_BITS-1:0]     head_address,
  output logic [DATA_WIDTH-1:0]    head_data,
  output logic [MICROOP_WIDTH-1:0] head_microop,
  output logic [TICKET_WIDTH-1:0]  head_ticket,
  output logic [SIZE_WIDTH-1:0]    head_size,
  input  logic [ADDR_BITS-1:0]     probe_address_i,
  output logic                     probe_store_hit_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     valid_o,
  output logic                     ready_o
);

  logic [ADDR_BITS-1:0]     addr_mem  [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem  [DEPTH];
  logic [MICROOP_WIDTH-1:0] mop_mem   [DEPTH];
  logic [TICKET_WIDTH-1:0]  tkt_mem   [DEPTH];
  logic [SIZE_WIDTH-1:0]    size_mem  [DEPTH];
  logic [DEPTH-1:0]         store_mem;

  logic [DEPTH-1:0] entry_valid, entry_fetched;
  logic [DEPTH-1:0] upd_match, probe_match;
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push, do_pop, push_upd_match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_cmp
    block_match_cmp #(.ADDR_BITS(ADDR_BITS), .BLOCK_ID_START(BLOCK_ID_START)) u_upd (
      .a(addr_mem[i]), .b(update_address_i), .match(upd_match[i])
    );
    block_match_cmp #(.ADDR_BITS(ADDR_BITS), .BLOCK_ID_START(BLOCK_ID_START)) u_probe (
      .a(addr_mem[i]), .b(probe_address_i), .match(probe_match[i])
    );
  end

  block_match_cmp #(.ADDR_BITS(ADDR_BITS), .BLOCK_ID_START(BLOCK_ID_START)) u_push_cmp (
    .a(write_address), .b(update_address_i), .match(push_upd_match)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && valid_o;
  assign do_push = push && (ready_o || do_pop);

  always_comb begin
    count_nxt = count_o;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count_o + CNT_W'(1);
      2'b01:   count_nxt = count_o - CNT_W'(1);
      default: count_nxt = count_o;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr      <= '0;
      tail_ptr      <= '0;
      count_o       <= '0;
      valid_o       <= 1'b0;
      ready_o       <= 1'b1;
      entry_valid   <= '0;
      entry_fetched <= '0;
    end else if (flush_i) begin
      head_ptr      <= '0;
      tail_ptr      <= '0;
      count_o       <= '0;
      valid_o       <= 1'b0;
      ready_o       <= 1'b1;
      entry_valid   <= '0;
      entry_fetched <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_update_i && entry_valid[i] && upd_match[i]) entry_fetched[i] <= 1'b1;
      end
      // NOTE: the push updates come after the pop ones so that, when a full
      // buffer pushes and pops the same slot, the last non-blocking write wins.
      if (do_pop) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= ptr_inc(head_ptr);
      end
      if (do_push) begin
        entry_valid[tail_ptr]   <= 1'b1;
        entry_fetched[tail_ptr] <= valid_update_i && push_upd_match;
        tail_ptr                <= ptr_inc(tail_ptr);
      end
      count_o <= count_nxt;
      valid_o <= (count_nxt != '0);
      ready_o <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // NOTE: payload storage is deliberately left unreset; entry_valid qualifies
  // every read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) begin
      addr_mem[tail_ptr]  <= write_address;
      data_mem[tail_ptr]  <= write_data;
      mop_mem[tail_ptr]   <= write_microop;
      tkt_mem[tail_ptr]   <= write_ticket;
      size_mem[tail_ptr]  <= write_size;
      store_mem[tail_ptr] <= is_store_class(write_microop[MOP_CLASS_LSB+1:MOP_CLASS_LSB]);
    end
  end

  always_comb begin
    head_is_store   = 1'b0;
    head_is_fetched = 1'b0;
    head_address    = '0;
    head_data       = '0;
    head_microop    = '0;
    head_ticket     = '0;
    head_size       = '0;
    if (valid_o) begin
      head_is_store   = store_mem[head_ptr];
      head_is_fetched = entry_fetched[head_ptr] || (valid_update_i && upd_match[head_ptr]);
      head_address    = addr_mem[head_ptr];
      head_data       = data_mem[head_ptr];
      head_microop    = mop_mem[head_ptr];
      head_ticket     = tkt_mem[head_ptr];
      head_size       = size_mem[head_ptr];
    end
  end

  // An entry pushed this cycle is not yet valid, so it never contributes.
  assign probe_store_hit_o = |(entry_valid & store_mem & probe_match);

  logic unused_microop;
  assign unused_microop = ^write_microop;

endmodule

// File: tb/tb_vls_req_buffer.sv
// Self-checking bench for vls_req_buffer (DEPTH=4): queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vls_req_buffer;

  localparam int DW = 32, AW = 32, BS = 5, MW = 7, TW = 5, SW = 3, DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [MW-1:0] MOP_STORE = 7'h18;  // bits [4:3] = 11
  localparam logic [MW-1:0] MOP_LOAD  = 7'h08;  // bits [4:3] = 01

  logic          clk = 1'b0, rst;
  logic          push, valid_update_i, flush_i, pop;
  logic [AW-1:0] write_address, update_address_i, probe_address_i;
  logic [DW-1:0] write_data;
  logic [TW-1:0] write_ticket;
  logic [MW-1:0] write_microop;
  logic [SW-1:0] write_size;
  logic          head_is_store, head_is_fetched, probe_store_hit_o, valid_o, ready_o;
  logic [AW-1:0] head_address;
  logic [DW-1:0] head_data;
  logic [MW-1:0] head_microop;
  logic [TW-1:0] head_ticket;
  logic [SW-1:0] head_size;
  logic [CW-1:0] count_o;

  vls_req_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .write_address(write_address),
    .write_data(write_data), .write_ticket(write_ticket), .write_microop(write_microop),
    .write_size(write_size), .valid_update_i(valid_update_i),
    .update_address_i(update_address_i), .flush_i(flush_i), .pop(pop),
    .head_is_store(head_is_store), .head_is_fetched(head_is_fetched),
    .head_address(head_address), .head_data(head_data), .head_microop(head_microop),
    .head_ticket(head_ticket), .head_size(head_size), .probe_address_i(probe_address_i),
    .probe_store_hit_o(probe_store_hit_o), .count_o(count_o), .valid_o(valid_o),
    .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mop;
    logic [TW-1:0] tkt;
    logic [SW-1:0] sz;
    bit            fetched;
  } ent_t;

  ent_t q[$];

  function automatic bit same_block(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a >> BS) == (b >> BS);
  endfunction

  function automatic bit is_store(input logic [MW-1:0] m);
    return ((m >> 3) & 7'd3) == 7'd3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush_i) begin
      q.delete();
    end else begin
      bit   ep, ap;
      ent_t e;
      if (valid_update_i)
        foreach (q[i]) if (same_block(q[i].addr, update_address_i)) q[i].fetched = 1'b1;
      ep = pop && (q.size() != 0);
      ap = push && ((q.size() < DEPTH) || ep);
      if (ep) void'(q.pop_front());
      if (ap) begin
        e.addr = write_address; e.data = write_data; e.mop = write_microop;
        e.tkt = write_ticket; e.sz = write_size;
        e.fetched = valid_update_i && same_block(write_address, update_address_i);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    bit hit;
    hit = 1'b0;
    foreach (q[i]) if (is_store(q[i].mop) && same_block(q[i].addr, probe_address_i)) hit = 1'b1;
    check("count", 64'(count_o), 64'(q.size()));
    check("valid", 64'(valid_o), 64'(q.size() != 0));
    check("ready", 64'(ready_o), 64'(q.size() != DEPTH));
    check("probe_hit", 64'(probe_store_hit_o), 64'(hit));
    if (q.size() != 0) begin
      check("head_address", 64'(head_address), 64'(q[0].addr));
      check("head_data", 64'(head_data), 64'(q[0].data));
      check("head_microop", 64'(head_microop), 64'(q[0].mop));
      check("head_ticket", 64'(head_ticket), 64'(q[0].tkt));
      check("head_size", 64'(head_size), 64'(q[0].sz));
      check("head_is_store", 64'(head_is_store), 64'(is_store(q[0].mop)));
      check("head_is_fetched", 64'(head_is_fetched),
            64'(q[0].fetched || (valid_update_i && same_block(q[0].addr, update_address_i))));
    end else begin
      check("head_zero", 64'({head_is_store, head_is_fetched, head_address, head_microop,
                              head_ticket, head_size}), 64'd0);
      check("head_data_zero", 64'(head_data), 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    push = 1'b0; pop = 1'b0; valid_update_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_push(input logic [AW-1:0] a, input logic [MW-1:0] m);
    push          = 1'b1;
    write_address = a;
    write_data    = a ^ 32'hA5A5_0000;
    write_ticket  = a[8:4];
    write_microop = m;
    write_size    = 3'd2;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [MW-1:0] m);
    set_push(a, m);
    tick();
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clr();
    write_address = '0; write_data = '0; write_ticket = '0; write_microop = '0;
    write_size = '0; update_address_i = '0; probe_address_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_probe", 64'(probe_store_hit_o), 64'd0);
    check("rst_head_addr", 64'(head_address), 64'd0);
    rst = 1'b0;
    tick();

    // Fill then drain
    push_one(32'h100, MOP_LOAD);
    push_one(32'h120, MOP_LOAD);
    push_one(32'h140, MOP_LOAD);
    push_one(32'h160, MOP_LOAD);
    check("fill_count", 64'(count_o), 64'd4);
    check("fill_ready", 64'(ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 64'(head_address), 64'(32'h100 + 32'(i) * 32'h20));
      pop_one();
    end
    check("drain_valid", 64'(valid_o), 64'd0);
    pop_one();  // pop while empty is ignored
    check("empty_pop_count", 64'(count_o), 64'd0);

    // Push+pop while full, with wrap-around
    push_one(32'h100, MOP_LOAD);
    push_one(32'h120, MOP_LOAD);
    push_one(32'h140, MOP_LOAD);
    push_one(32'h160, MOP_LOAD);
    push_one(32'h1A0, MOP_LOAD);  // dropped: full, no pop
    check("drop_count", 64'(count_o), 64'd4);
    set_push(32'h180, MOP_LOAD);
    pop = 1'b1;
    tick();
    check("pushpop_count", 64'(count_o), 64'd4);
    check("pushpop_head", 64'(head_address), 64'h120);
    repeat (3) pop_one();
    check("wrap_head", 64'(head_address), 64'h180);
    pop_one();

    // Update fan-out
    push_one(32'h200, MOP_LOAD);
    push_one(32'h204, MOP_LOAD);
    push_one(32'h240, MOP_LOAD);
    check("pre_upd_fetched", 64'(head_is_fetched), 64'd0);
    valid_update_i = 1'b1;
    update_address_i = 32'h21C;
    #1;
    check("upd_same_cycle", 64'(head_is_fetched), 64'd1);
    tick();
    check("upd_head0", 64'(head_is_fetched), 64'd1);
    pop_one();
    check("upd_head1_addr", 64'(head_address), 64'h204);
    check("upd_head1", 64'(head_is_fetched), 64'd1);
    pop_one();
    check("upd_head2_addr", 64'(head_address), 64'h240);
    check("upd_head2", 64'(head_is_fetched), 64'd0);
    pop_one();

    // Push during a matching update
    set_push(32'h300, MOP_LOAD);
    valid_update_i = 1'b1;
    update_address_i = 32'h310;
    tick();
    check("push_upd_fetched", 64'(head_is_fetched), 64'd1);
    pop_one();

    // Probe
    push_one(32'h400, MOP_STORE);
    push_one(32'h500, MOP_LOAD);
    check("probe_head_store", 64'(head_is_store), 64'd1);
    probe_address_i = 32'h41F;
    #1;
    check("probe_store_hit", 64'(probe_store_hit_o), 64'd1);
    probe_address_i = 32'h500;
    #1;
    check("probe_load_miss", 64'(probe_store_hit_o), 64'd0);
    probe_address_i = 32'h600;
    set_push(32'h600, MOP_STORE);
    #1;
    check("probe_push_excluded", 64'(probe_store_hit_o), 64'd0);
    tick();
    check("probe_after_push", 64'(probe_store_hit_o), 64'd1);

    // Flush with simultaneous push at count 3
    check("pre_flush_count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    set_push(32'h700, MOP_STORE);
    tick();
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(valid_o), 64'd0);

    // Reset mid-stream
    push_one(32'h800, MOP_STORE);
    push_one(32'h820, MOP_LOAD);
    probe_address_i = 32'h800;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    check("mid_rst_count", 64'(count_o), 64'd0);
    check("mid_rst_probe", 64'(probe_store_hit_o), 64'd0);
    check("mid_rst_head", 64'(head_address), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    push_one(32'h900, MOP_LOAD);
    check("post_rst_head", 64'(head_address), 64'h900);
    pop_one();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vls_req_buffer.md
VLS_REQ_BUFFER -- requirements
Module: vls_req_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data bits per entry.
REQ-002 SHALL have parameter ADDR_BITS, default 32, the address bits.
REQ-003 SHALL have parameter BLOCK_ID_START, default 5, the lowest bit of the cache-block ID.
REQ-004 SHALL have parameters MICROOP_WIDTH (default 7), TICKET_WIDTH (default 5) and SIZE_WIDTH (default 3).
REQ-005 SHALL have parameter DEPTH, default 6; any value >=2 is legal, including non-powers of two.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port push, input, 1 bit: enqueue request.
REQ-009 SHALL have ports write_address/write_data/write_ticket/write_microop/write_size, inputs, parameter widths: the enqueue payload.
REQ-010 SHALL have port valid_update_i, input, 1 bit: a block fill is complete.
REQ-011 SHALL have port update_address_i, input, ADDR_BITS: the filled block address.
REQ-012 SHALL have port flush_i, input, 1 bit: discard all entries.
REQ-013 SHALL have port pop, input, 1 bit: dequeue the head.
REQ-014 SHALL have ports head_is_store, head_is_fetched, head_address, head_data, head_microop, head_ticket, head_size, outputs: the head entry.
REQ-015 SHALL have port probe_address_i, input, ADDR_BITS: the hazard-check address.
REQ-016 SHALL have port probe_store_hit_o, output, 1 bit: a valid store to the probed block is present.
REQ-017 SHALL have port count_o, output, $clog2(DEPTH+1) bits: the occupancy.
REQ-018 SHALL have ports valid_o (not empty) and ready_o (not full), outputs, 1 bit each.

Function
REQ-019 SHALL be a FIFO with binary head/tail pointers; each pointer wraps from DEPTH-1 to 0.
REQ-020 SHALL accept a push when ready_o=1, or when full with pop asserted in the same cycle; a push to a full buffer without pop SHALL be dropped with no state change.
REQ-021 SHALL ignore pop while valid_o=0.
REQ-022 SHALL, on an accepted push and an effective pop in the same cycle, leave count_o unchanged and advance both pointers.
REQ-023 SHALL classify an entry as a store when write_microop[4:3]==2'b11.
REQ-024 SHALL give flush_i priority over push and pop: next cycle all entries are invalid, pointers are 0 and count_o=0.
REQ-025 SHALL define a block match as equality of address bits [ADDR_BITS-1:BLOCK_ID_START].
REQ-026 SHALL set is_fetched on every valid entry whose block matches update_address_i when valid_update_i=1.
REQ-027 SHALL write an entry pushed in the same cycle as a matching update with is_fetched=1; otherwise a pushed entry SHALL start with is_fetched=0.
REQ-028 SHALL compute head_is_fetched combinationally as the stored bit OR (valid_update_i AND head block match), giving zero-latency visibility of an update at the head.
REQ-029 SHALL drive all head_* outputs to 0 when valid_o=0.
REQ-030 SHALL make probe_store_hit_o combinational: the OR over valid store entries whose block matches probe_address_i, excluding an entry being pushed in the same cycle.
REQ-031 SHALL register count_o, valid_o and ready_o, with valid_o=(count_o!=0) and ready_o=(count_o!=DEPTH).

Reset
REQ-032 SHALL, while rst=1, asynchronously clear the pointers, count_o, all valid bits and all is_fetched bits.
REQ-033 SHALL present, during and after reset, valid_o=0, ready_o=1, count_o=0, probe_store_hit_o=0 and all head_* outputs=0.
REQ-034 SHALL treat reset asserted mid-operation as discarding all entries; the payload arrays SHALL be non-reset storage.

Structure
REQ-035 SHALL take the store-microop decode constant (2'b11 at bits [4:3]) and the default widths from the shared vector-memory package.
REQ-036 SHALL have exactly one sub-module, block_match_cmp (parametrised block-ID comparator), instanced per entry for the update and probe searches.

Verification
REQ-037 SHALL cover fill then drain (DEPTH=4): 4 pushes at 0x100/0x120/0x140/0x160 -> ready_o=0, count_o=4; 4 pops -> heads returned in order, valid_o=0.
REQ-038 SHALL cover push+pop while full (DEPTH=4): push 0x180 with pop -> count_o stays 4, and after 3 more pops the head address is 0x180 (wrap-around checked).
REQ-039 SHALL cover update fan-out: entries at 0x200, 0x204 and 0x240, then update 0x21C -> the first two are fetched and the third is not; head_is_fetched=1 in the update cycle itself.
REQ-040 SHALL cover push during update: push 0x300 while updating 0x310 -> the entry reaches the head with head_is_fetched=1 and no further update.
REQ-041 SHALL cover probe: a store (microop[4:3]=11) at 0x400 plus a load at 0x500 -> probing 0x41F gives hit=1 and probing 0x500 gives hit=0.
REQ-042 SHALL cover flush/reset: flush_i with push in the same cycle at count_o=3 -> count_o=0 and valid_o=0 next cycle; rst pulsed mid-stream -> all outputs at reset values.
